// File: rtl/sys_pkg.sv
// -----------------------------------------------------------------------------
// sys_pkg
// Shared definitions for the systolic-array front end (sys_skew and friends).
//   sys_skew_state_t : control states of the skew transmitter
//   cnt_width()      : counter width helper, never narrower than one bit
// -----------------------------------------------------------------------------
package sys_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,  // waiting for the first vector of a frame
    FILL  = 2'd1,  // accepting vectors 1 .. ImageSize-1
    FLUSH = 2'd2   // draining the trailing zero triangle
  } sys_skew_state_t;

  // Bits needed to hold values 0 .. max_count-1; a one-value counter still
  // gets a single bit so that the register is never zero-width.
  function automatic int cnt_width(input int max_count);
    return (max_count <= 1) ? 1 : $clog2(max_count);
  endfunction

endpackage

// File: rtl/sys_skew_lane_delay.sv
// -----------------------------------------------------------------------------
// lane_delay
// Enabled shift register used as the per-lane delay line of sys_skew.
// A lane with Depth stages presents, after each enabled shift, the value that
// was shifted in Depth shifts earlier.
//
// Parameters:
//   BitSize : operand width
//   Depth   : number of stages (>= 1)
// Ports:
//   clk   : clock, rising edge
//   res   : asynchronous active-high reset, clears every stage
//   en_i  : shift enable; stages hold when low
//   clr_i : synchronous clear; combined with en_i the new operand is still
//           captured into stage 0 while every older stage is zeroed
//   d_i   : operand shifted into stage 0
//   q_o   : oldest stage
// -----------------------------------------------------------------------------
module lane_delay #(
  parameter int BitSize = 4,
  parameter int Depth   = 1
) (
  input  logic               clk,
  input  logic               res,
  input  logic               en_i,
  input  logic               clr_i,
  input  logic [BitSize-1:0] d_i,
  output logic [BitSize-1:0] q_o
);

  logic [Depth-1:0][BitSize-1:0] stage_q;
  logic [Depth-1:0][BitSize-1:0] stage_d;

  always_comb begin
    // NOTE: default assignment first so every path writes stage_d (no latch).
    stage_d = stage_q;
    if (en_i) begin
      stage_d[0] = d_i;
      for (int i = 1; i < Depth; i++) begin
        stage_d[i] = clr_i ? '0 : stage_q[i-1];
      end
    end else if (clr_i) begin
      stage_d = '0;
    end
  end

  // NOTE: the delay stages are reset because a discarded frame must not leak
  // operands into the next one; this is state, not a scratch memory.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      stage_q <= '0;
    end else begin
      // NOTE: non-blocking so all stages update from the pre-edge values.
      stage_q <= stage_d;
    end
  end

  assign q_o = stage_q[Depth-1];

endmodule

// File: rtl/sys_skew.sv
// -----------------------------------------------------------------------------
// sys_skew
// Front-end transmitter for the systolic summation array. Accepts one
// lane-aligned vector of NumOfNerves operands per cycle, ImageSize vectors per
// frame, and re-emits each frame diagonally skewed: lane k is delayed k
// slices, with zeros filling the leading and trailing triangles. A frame
// occupies ImageSize+NumOfNerves-1 output slices when not stalled.
//
// Optional feature macro: SYS_SKEW_ERR_EN
//   defined   : adds the sticky 'err' output (bad in_start usage)
//   undefined : no 'err' port; bad in_start usage is handled silently
//
// Parameters:
//   BitSize     : operand width
//   NumOfNerves : lane count (>= 1)
//   ImageSize   : vectors per frame (>= 1)
// Ports:
//   clk       : clock, rising edge
//   res       : asynchronous active-high reset
//   in_valid  : input vector present
//   in_start  : first vector of a frame
//   in_data   : aligned vector, lane 0 at index 0
//   in_ready  : vector accepted this cycle when in_valid is high
//   out_valid : skewed slice valid
//   out_start : first slice of a frame
//   out_data  : skewed slice, zero whenever out_valid is low
//   err       : sticky protocol-error flag (SYS_SKEW_ERR_EN only)
// -----------------------------------------------------------------------------
module sys_skew
  import sys_pkg::*;
#(
  parameter int BitSize     = 4,
  parameter int NumOfNerves = 2,
  parameter int ImageSize   = 3
) (
  input  logic                                clk,
  input  logic                                res,
  input  logic                                in_valid,
  input  logic                                in_start,
  input  logic [NumOfNerves-1:0][BitSize-1:0] in_data,
  output logic                                in_ready,
  output logic                                out_valid,
  output logic                                out_start,
  output logic [NumOfNerves-1:0][BitSize-1:0] out_data
`ifdef SYS_SKEW_ERR_EN
  ,
  output logic                                err
`endif
);

  localparam int VecW   = cnt_width(ImageSize + 1);
  localparam int FlushW = cnt_width(NumOfNerves);

  localparam logic [VecW-1:0]   LastVec   = VecW'(ImageSize - 1);
  localparam logic [FlushW-1:0] LastFlush = FlushW'(NumOfNerves - 2);

  // A single-lane array has no trailing triangle, so the frame ends with its
  // last accepted vector and FLUSH is skipped entirely.
  localparam bit SingleVec  = (ImageSize == 1);
  localparam bit SingleLane = (NumOfNerves == 1);

  sys_skew_state_t state_q, state_d;
  logic [VecW-1:0]   vec_cnt_q, vec_cnt_d;
  logic [FlushW-1:0] flush_cnt_q, flush_cnt_d;

  logic                                out_valid_q, out_start_q;
  logic [NumOfNerves-1:0][BitSize-1:0] out_data_q, out_data_d;

  logic shift_en;     // advance every lane by one slice this cycle
  logic frame_start;  // accepted vector 0 of a new frame
  logic flushing;     // shifting zeros in the trailing triangle

  // ---------------------------------------------------------------------------
  // Control: next state, counters, handshake
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    vec_cnt_d   = vec_cnt_q;
    flush_cnt_d = flush_cnt_q;
    in_ready    = 1'b1;
    shift_en    = 1'b0;
    frame_start = 1'b0;
    flushing    = 1'b0;

    unique case (state_q)
      IDLE: begin
        // A vector without in_start outside a frame is dropped unshifted.
        if (in_valid && in_start) begin
          shift_en    = 1'b1;
          frame_start = 1'b1;
          vec_cnt_d   = VecW'(1);
          if (SingleVec) begin
            state_d     = SingleLane ? IDLE : FLUSH;
            vec_cnt_d   = '0;
            flush_cnt_d = '0;
          end else begin
            state_d = FILL;
          end
        end
      end

      FILL: begin
        // in_start here is ordinary data; a missing in_valid is a stall.
        if (in_valid) begin
          shift_en  = 1'b1;
          vec_cnt_d = vec_cnt_q + VecW'(1);
          if (vec_cnt_q == LastVec) begin
            state_d     = SingleLane ? IDLE : FLUSH;
            vec_cnt_d   = '0;
            flush_cnt_d = '0;
          end
        end
      end

      FLUSH: begin
        in_ready    = 1'b0;
        shift_en    = 1'b1;
        flushing    = 1'b1;
        flush_cnt_d = flush_cnt_q + FlushW'(1);
        if (flush_cnt_q == LastFlush) begin
          state_d     = IDLE;
          flush_cnt_d = '0;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Lanes: lane 0 feeds the output register directly, lane k goes through a
  // k-deep delay line. The first slice of a frame carries only lane 0.
  // ---------------------------------------------------------------------------
  for (genvar k = 0; k < NumOfNerves; k++) begin : g_lane
    if (k == 0) begin : g_pass
      assign out_data_d[0] = (shift_en && !flushing) ? in_data[0] : '0;
    end else begin : g_delay
      logic [BitSize-1:0] din;
      logic [BitSize-1:0] tap;

      assign din = flushing ? '0 : in_data[k];

      lane_delay #(
        .BitSize (BitSize),
        .Depth   (k)
      ) u_delay (
        .clk   (clk),
        .res   (res),
        .en_i  (shift_en),
        .clr_i (frame_start),
        .d_i   (din),
        .q_o   (tap)
      );

      assign out_data_d[k] = (shift_en && !frame_start) ? tap : '0;
    end
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_q     <= IDLE;
      vec_cnt_q   <= '0;
      flush_cnt_q <= '0;
      out_valid_q <= 1'b0;
      out_start_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      vec_cnt_q   <= vec_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      out_valid_q <= shift_en;
      out_start_q <= frame_start;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_start = out_start_q;
  assign out_data  = out_data_q;

`ifdef SYS_SKEW_ERR_EN
  // Sticky: a stray vector outside a frame, or a start marker inside one.
  logic err_q;
  logic err_d;

  assign err_d = err_q
               | ((state_q == IDLE) & in_valid & ~in_start)
               | ((state_q == FILL) & in_valid &  in_start);

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`endif

endmodule

// File: tb/tb_sys_skew.sv
// -----------------------------------------------------------------------------
// tb_sys_skew
// Self-checking bench for sys_skew. Frames are issued by a driver that pushes
// the expected skewed slices into a queue; a monitor on the falling edge pops
// and compares whenever out_valid is high. A second, single-lane single-vector
// instance covers the degenerate configuration.
// -----------------------------------------------------------------------------
module tb_sys_skew;

  localparam int B = 4;
  localparam int N = 2;
  localparam int I = 3;

  typedef logic [N-1:0][B-1:0] vec_t;
  typedef struct packed {
    logic start;
    vec_t data;
  } slice_t;

  logic clk = 1'b0;
  logic res;
  always #5 clk = ~clk;

  // main instance
  logic in_valid, in_start, in_ready, out_valid, out_start;
  vec_t in_data, out_data;
  // degenerate instance
  logic        v1, s1, r1, ov1, os1;
  logic [0:0][B-1:0] d1, od1;
`ifdef SYS_SKEW_ERR_EN
  logic err, err1;
`endif

  sys_skew #(.BitSize(B), .NumOfNerves(N), .ImageSize(I)) dut (
    .clk       (clk),
    .res       (res),
    .in_valid  (in_valid),
    .in_start  (in_start),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_start (out_start),
    .out_data  (out_data)
`ifdef SYS_SKEW_ERR_EN
    ,
    .err       (err)
`endif
  );

  sys_skew #(.BitSize(B), .NumOfNerves(1), .ImageSize(1)) dut1 (
    .clk       (clk),
    .res       (res),
    .in_valid  (v1),
    .in_start  (s1),
    .in_data   (d1),
    .in_ready  (r1),
    .out_valid (ov1),
    .out_start (os1),
    .out_data  (od1)
`ifdef SYS_SKEW_ERR_EN
    ,
    .err       (err1)
`endif
  );

  int     total = 0;
  int     bad   = 0;
  slice_t exp_q[$];
  vec_t   frame[I];
  bit     b2b_pending = 1'b0;
  bit     mon_en = 1'b0;
  int     run = 0;
  int     max_run = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: compares every presented slice against the queue head
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    if (res) begin
      run = 0;
    end else if (mon_en) begin
      if (out_valid) begin
        run++;
        if (run > max_run) max_run = run;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_slice: got start=%0b data=%0h with nothing expected at %0t",
                   out_start, out_data, $time);
        end else begin
          slice_t s;
          s = exp_q.pop_front();
          check("slice_start", 32'(out_start), 32'(s.start));
          check("slice_data", 32'(out_data), 32'(s.data));
        end
      end else begin
        run = 0;
        check("bubble_data_zero", 32'(out_data), 0);
        check("bubble_start_zero", 32'(out_start), 0);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Reference: slice j, lane k carries vector j-k when it exists, else zero
  // ---------------------------------------------------------------------------
  task automatic push_expect(input int n_slices);
    for (int j = 0; j < n_slices; j++) begin
      slice_t s;
      s.start = (j == 0);
      s.data  = '0;
      for (int k = 0; k < N; k++) begin
        if (j - k >= 0 && j - k < I) s.data[k] = frame[j-k][k];
      end
      exp_q.push_back(s);
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_start = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
    if (n > 0) b2b_pending = 1'b0;
  endtask

  // Sends n_send vectors of 'frame'. fix_n stall cycles precede vector fix_v;
  // up to rand_max random stall cycles precede every other vector after 0.
  // 'dirty' raises in_start on vector 1 as well.
  task automatic send_frame(input int n_send, input int rand_max,
                            input int fix_v, input int fix_n, input bit dirty);
    int waited;
    int stalls;
    push_expect((n_send == I) ? I + N - 1 : n_send);
    for (int v = 0; v < n_send; v++) begin
      if (v > 0) begin
        stalls = (v == fix_v) ? fix_n : ((rand_max > 0) ? $urandom_range(0, rand_max) : 0);
        in_valid = 1'b0;
        in_start = 1'b0;
        repeat (stalls) begin
          @(posedge clk);
          #1;
        end
      end
      in_valid = 1'b1;
      in_start = (v == 0) || (dirty && v == 1);
      in_data  = frame[v];
      waited   = 0;
      while (!in_ready && waited < 50) begin
        @(posedge clk);
        #1;
        waited++;
      end
      if (!in_ready) check("ready_timeout", 32'(in_ready), 1);
      if (v == 0 && b2b_pending) check("ready_low_cycles", 32'(waited), 32'(N - 1));
      @(posedge clk);
      #1;
    end
    in_valid    = 1'b0;
    in_start    = 1'b0;
    b2b_pending = (n_send == I);
  endtask

  task automatic do_reset();
    res = 1'b1;
    exp_q.delete();
    in_valid = 1'b0;
    in_start = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_start", 32'(out_start), 0);
    check("rst_out_data", 32'(out_data), 0);
    check("rst_in_ready", 32'(in_ready), 1);
`ifdef SYS_SKEW_ERR_EN
    check("rst_err", 32'(err), 0);
`endif
    @(posedge clk);
    #1;
    res = 1'b0;
    b2b_pending = 1'b0;
    idle(2);
  endtask

  task automatic rand_frame();
    for (int v = 0; v < I; v++) begin
      for (int k = 0; k < N; k++) frame[v][k] = B'($urandom);
    end
  endtask

  task automatic basic_frame();
    for (int v = 0; v < I; v++) begin
      for (int k = 0; k < N; k++) frame[v][k] = B'(2 * v + k + 1);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    res = 1'b1;
    in_valid = 1'b0;
    in_start = 1'b0;
    in_data  = '0;
    v1 = 1'b0;
    s1 = 1'b0;
    d1 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_out_valid", 32'(out_valid), 0);
    check("reset_out_start", 32'(out_start), 0);
    check("reset_out_data", 32'(out_data), 0);
    check("reset_in_ready", 32'(in_ready), 1);
    res = 1'b0;
    mon_en = 1'b1;
    idle(1);

    // basic frame: (1,2) (3,4) (5,6)
    basic_frame();
    max_run = 0;
    send_frame(I, 0, 0, 0, 1'b0);
    idle(4);
    check("basic_valid_run", 32'(max_run), 32'(I + N - 1));

    // back-to-back frames, second one starting with (7,8)
    max_run = 0;
    send_frame(I, 0, 0, 0, 1'b0);
    frame[0][0] = 4'd7;
    frame[0][1] = 4'd8;
    send_frame(I, 0, 0, 0, 1'b0);
    idle(4);
    check("b2b_valid_run", 32'(max_run), 32'(2 * (I + N - 1)));

    // two-cycle stall between V1 and V2
    basic_frame();
    max_run = 0;
    send_frame(I, 0, 2, 2, 1'b0);
    idle(4);
    check("stall_valid_run", 32'(max_run), 2);

    // reset after V1, then a fresh frame with no residue
    send_frame(2, 0, 0, 0, 1'b0);
    do_reset();
    rand_frame();
    send_frame(I, 0, 0, 0, 1'b0);
    idle(4);

    // stray vector (9,9) outside a frame is dropped
    in_valid = 1'b1;
    in_start = 1'b0;
    in_data  = {4'd9, 4'd9};
    @(posedge clk);
    #1;
    idle(4);
`ifdef SYS_SKEW_ERR_EN
    check("err_after_stray", 32'(err), 1);
`endif
    // start marker on V1 is plain data
    rand_frame();
    send_frame(I, 0, 0, 0, 1'b1);
    idle(4);
`ifdef SYS_SKEW_ERR_EN
    check("err_sticky", 32'(err), 1);
    do_reset();
    rand_frame();
    send_frame(I, 0, 0, 0, 1'b1);
    idle(4);
    check("err_start_in_fill", 32'(err), 1);
    do_reset();
`endif

    // randomized frames with random stalls and gaps (gap 0 = back-to-back)
    for (int f = 0; f < 24; f++) begin
      rand_frame();
      send_frame(I, 2, 0, 0, 1'b0);
      idle($urandom_range(0, 2));
    end
    idle(6);
    check("queue_drained", 32'(exp_q.size()), 0);

    // degenerate instance: one lane, one vector per frame
    v1 = 1'b1;
    s1 = 1'b1;
    d1 = 4'd5;
    check("deg_ready_pre", 32'(r1), 1);
    @(posedge clk);
    #1;
    check("deg_valid", 32'(ov1), 1);
    check("deg_start", 32'(os1), 1);
    check("deg_data", 32'(od1), 5);
    check("deg_ready", 32'(r1), 1);
    d1 = 4'hA;
    @(posedge clk);
    #1;
    check("deg_b2b_valid", 32'(ov1), 1);
    check("deg_b2b_start", 32'(os1), 1);
    check("deg_b2b_data", 32'(od1), 32'hA);
    check("deg_b2b_ready", 32'(r1), 1);
    s1 = 1'b0;
    d1 = 4'd3;
    @(posedge clk);
    #1;
    check("deg_drop_valid", 32'(ov1), 0);
    check("deg_drop_data", 32'(od1), 0);
    v1 = 1'b0;
    @(posedge clk);
    #1;
    check("deg_idle_valid", 32'(ov1), 0);
    check("deg_idle_ready", 32'(r1), 1);
`ifdef SYS_SKEW_ERR_EN
    check("deg_err", 32'(err1), 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/sys_skew.md
# sys_skew

Front-end transmitter for the systolic summation array. It accepts one lane-aligned vector of `NumOfNerves` operands per cycle, `ImageSize` vectors per frame. It re-emits each frame as a diagonally skewed stream: lane k is delayed k cycles, and zeros fill the leading and trailing triangles. The output is the exact `in_valid`/`in_start`/`in_data` stream the systolic sum array consumes, and sits directly upstream of it.

## Interface
Parameters:
- `BitSize`, 4, width of one operand
- `NumOfNerves`, 2, lane count; must be ≥1
- `ImageSize`, 3, vectors per frame; must be ≥1

Ports (clock and reset first):
- `clk` in 1: single clock, rising edge
- `res` in 1: asynchronous, active-high reset
- `in_valid` in 1: input vector present
- `in_start` in 1: marks the first vector of a frame
- `in_data` in [NumOfNerves-1:0][BitSize-1:0]: aligned vector, lane 0 = index 0
- `in_ready` out 1: block accepts a vector this cycle
- `out_valid` out 1: skewed slice valid
- `out_start` out 1: first slice of a frame
- `out_data` out [NumOfNerves-1:0][BitSize-1:0]: skewed slice
- `err` out 1: only with `SYS_SKEW_ERR_EN`

## Operation
- Accept = `in_valid & in_ready`.
- Lane k is held in a k-deep enabled delay line. Lane 0 is pass-through into the output register.
- FSM states: IDLE, FILL, FLUSH.
- **IDLE:**
  - `in_ready`=1.
  - An accept with `in_start`=1 consumes vector 0, sets `vec_cnt`=1, and moves to FILL.
  - If `ImageSize`==1, it goes straight to FLUSH instead, or to IDLE when `NumOfNerves`==1.
  - An accept with `in_start`=0 is dropped; nothing is shifted.
- **FILL:**
  - `in_ready`=1.
  - Each accept shifts all delay lines and increments `vec_cnt`.
  - After vector `ImageSize`-1 is accepted, go to FLUSH, or to IDLE when `NumOfNerves`==1.
  - A cycle with `in_valid`=0 stalls: delay lines hold and `out_valid`=0.
  - `in_start`=1 during FILL is treated as ordinary data.
- **FLUSH:**
  - `in_ready`=0.
  - Shift zeros into every lane for `NumOfNerves`-1 cycles (`flush_cnt`), then go to IDLE.
- Output slice j of a frame, for j = 0 .. ImageSize+NumOfNerves-2: lane k carries vector (j-k) when 0 ≤ j-k < ImageSize, else 0.
- `out_start`=1 on slice 0 only.
- `out_data`=0 whenever `out_valid`=0.
- Delay lines are cleared to zero on every IDLE→FILL transition, so no data carries across frames.
- No arithmetic is performed; operands pass bit-exact.
- Counter widths: `vec_cnt` is $clog2(ImageSize+1) bits; `flush_cnt` is $clog2(NumOfNerves) bits, minimum 1.

## Timing
- Reset value of all outputs: `out_valid`=0, `out_start`=0, `out_data`=0, `err`=0. `in_ready`=1, since reset enters IDLE.
- `res` asserted mid-frame: the FSM returns to IDLE, all delay lines and counters clear, and the frame is discarded with no flush.
- Latency: a vector accepted at edge e drives its lane-0 slice on `out_data` immediately after edge e (one registered stage).
- An unstalled frame occupies exactly ImageSize+NumOfNerves-1 consecutive `out_valid` cycles.
- `in_ready` goes low the cycle after the last vector is accepted and stays low for NumOfNerves-1 cycles.
- The next frame's `in_start` may be accepted on the first IDLE cycle. Back-to-back frames therefore show no `out_valid` gap.
- A stall in FILL produces a `out_valid`=0 bubble. The downstream array must tolerate bubbles between `out_start` and the final slice.

## Configuration
- `SYS_SKEW_ERR_EN` defined:
  - adds the `err` port;
  - `err` is a sticky flag set on an accepted `in_start`=0 in IDLE, or `in_start`=1 during FILL;
  - `err` is cleared only by `res`.
- Macro undefined: no `err` port and no error logic; these violations are handled silently as above.

## Structure
- Shared package `sys_pkg`:
  - state enum typedef `sys_skew_state_t` (IDLE, FILL, FLUSH);
  - `$clog2`-based width helper function for counters.
- Sub-module `lane_delay`:
  - parameters `BitSize` and `Depth`;
  - synchronous enable and synchronous clear;
  - instantiated by generate for lanes 1..NumOfNerves-1.

## Test plan
- **Basic frame.** Defaults. V0=(l0=1,l1=2), V1=(3,4), V2=(5,6) on consecutive cycles with `in_start` on V0.
  - Expected slices: (1,0) start, (3,2), (5,4), (0,6).
  - `out_valid` is high for 4 cycles; `in_ready` is low 1 cycle.
- **Back-to-back frames.** Second frame V0=(7,8) presented on the first IDLE cycle.
  - Expected: (0,6) immediately followed by (7,0) with `out_start`=1; no `out_valid` gap.
- **Stall in FILL.** `in_valid`=0 for 2 cycles between V1 and V2.
  - Expected: 2 bubbles after (3,2), then (5,4), (0,6) unchanged.
- **Reset mid-frame.** Pulse `res` after V1 is accepted.
  - Expected: outputs go 0 asynchronously, `in_ready`=1, and no flush slice appears.
  - A new frame then produces correct output with no residue.
- **Protocol violation.** `in_valid`=1, `in_start`=0 in IDLE with data (9,9).
  - Expected: dropped, no `out_valid`.
  - With `SYS_SKEW_ERR_EN`: `err`=1 and stays set until `res`.
- **Degenerate parameters.** NumOfNerves=1, ImageSize=1, single vector (5).
  - Expected: one slice (5) with `out_start`=1; `in_ready` never drops.
